// File: rtl/jstk_spi_slave_pkg.sv
// Shared definitions for the PmodJSTK SPI slave: frame geometry, FSM states,
// LED command decode constants and the TX frame packing helper.
package jstk_pkg;

  localparam int FRAME_BYTES = 5;
  localparam int FRAME_BITS  = 8 * FRAME_BYTES;
  localparam int CNT_W       = 6;

  localparam logic [CNT_W-1:0] FRAME_BITS_CNT = CNT_W'(FRAME_BITS);

  localparam logic [7:0] LED_CMD_MASK  = 8'hFC;
  localparam logic [7:0] LED_CMD_VALUE = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Byte 0 (X low) sits in [7:0] and goes out first on MISO.
  function automatic logic [FRAME_BITS-1:0] pack_tx(input logic [9:0] x,
                                                    input logic [9:0] y,
                                                    input logic [2:0] btn);
    return {5'b0, btn, 6'b0, y[9:8], y[7:0], 6'b0, x[9:8], x[7:0]};
  endfunction

endpackage

// File: rtl/jstk_spi_slave_if.sv
// SPI pin bundle between a joystick master and the emulating slave.
interface jstk_spi_slave_if;

  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output ss_n, output mosi, input miso);
  modport slave  (input sclk, input ss_n, input mosi, output miso);

endinterface

// File: rtl/jstk_spi_slave_sync.sv
// Multi-flop synchronizer with a history flop providing rise/fall strobes
// in the system clock domain.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level_o = sync_q[STAGES-1];
  assign rise_o  = sync_q[STAGES-1] & ~hist_q;
  assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/jstk_spi_slave.sv
// SPI mode-0 slave emulating the PmodJSTK: returns a 40-bit X/Y/button frame
// and decodes the master's first byte into LED state.
module jstk_spi_slave
  import jstk_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  jstk_spi_slave_if.slave       spi,
  input  logic [9:0]            x_i,
  input  logic [9:0]            y_i,
  input  logic [2:0]            btn_i,
  output logic [1:0]            led_o,
  output logic [FRAME_BITS-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  frame_err_o
);

  logic sclk_rise, sclk_fall, sclk_lvl_unused;
  logic ss_rise, ss_fall, ss_lvl_unused;
  logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi.sclk),
    .level_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  // SS resets high so a deselected bus never produces a spurious start.
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi.ss_n),
    .level_o(ss_lvl_unused), .rise_o(ss_rise), .fall_o(ss_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .rst_ni(rst_ni), .d_i(spi.mosi),
    .level_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  overrun_q, overrun_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [FRAME_BITS-1:0] rx_q, rx_d;
  logic                  miso_q, miso_d;
  logic [1:0]            led_q, led_d;
  logic [FRAME_BITS-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;

  // Frame bit n lives in byte n/8, transmitted MSB first within the byte.
  function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] cnt);
    return {cnt[5:3], ~cnt[2:0]};
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      overrun_q   <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_q      <= 1'b0;
      led_q       <= 2'b00;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      overrun_q   <= overrun_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_q      <= miso_d;
      led_q       <= led_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    overrun_d   = overrun_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_d      = miso_q;
    led_d       = led_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        miso_d    = 1'b0;
        bit_cnt_d = '0;
        overrun_d = 1'b0;
        if (ss_fall) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        tx_d      = pack_tx(x_i, y_i, btn_i);
        miso_d    = tx_d[7];
        bit_cnt_d = '0;
        overrun_d = 1'b0;
        state_d   = ST_SHIFT;
      end

      ST_SHIFT: begin
        if (sclk_rise) begin
          if (bit_cnt_q == FRAME_BITS_CNT) begin
            overrun_d = 1'b1;
          end else begin
            rx_d[bit_pos(bit_cnt_q)] = mosi_lvl;
            bit_cnt_d = bit_cnt_q + 6'd1;
          end
        end else if (sclk_fall && (bit_cnt_q < FRAME_BITS_CNT)) begin
          miso_d = tx_q[bit_pos(bit_cnt_q)];
        end
        // SS is evaluated against the post-SCLK counter so a same-cycle last edge counts.
        if (ss_rise) begin
          miso_d = 1'b0;
          if ((bit_cnt_d == FRAME_BITS_CNT) && !overrun_d) begin
            state_d = ST_DONE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_DONE: begin
        miso_d     = 1'b0;
        rx_data_d  = rx_q;
        rx_valid_d = 1'b1;
        if ((rx_q[7:0] & LED_CMD_MASK) == LED_CMD_VALUE) led_d = rx_q[1:0];
        state_d = ss_fall ? ST_LOAD : ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign spi.miso    = miso_q;
  assign led_o       = led_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign frame_err_o = frame_err_q;

endmodule
